// File: rtl/dpram_bist.sv
// dpram_bist: cross-port march self-test controller for a dual-port RAM
module dpram_bist #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_port,
  output logic              ram_en,
  output logic              ram_wr0,
  output logic              ram_wr1,
  output logic [ADDR_W-1:0] ram_add0,
  output logic [ADDR_W-1:0] ram_add1,
  output logic [DATA_W-1:0] ram_data0_in,
  output logic [DATA_W-1:0] ram_data1_in,
  input  logic [DATA_W-1:0] ram_data0_out,
  input  logic [DATA_W-1:0] ram_data1_out
);
  typedef enum logic [2:0] {IDLE, WR_T, RD_T, WR_I, RD_I, CHECK, DONE} state_t;

  state_t              st, nxt_st;
  logic [ADDR_W-2:0]   k, nxt_k;
  logic                last, go, phase, nxt_wr, nxt_rd, nxt_inv;
  logic [ADDR_W-1:0]   ev, od;
  logic                cmp_v, m0, m1;
  logic [DATA_W-1:0]   exp0, exp1;
  logic [ADDR_W-1:0]   cmp_a0, cmp_a1;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
    logic [DATA_W-1:0] p;
    p = SEED ^ DATA_W'(a);
    return inv ? ~p : p;
  endfunction

  assign busy = phase || st == CHECK;
  assign done = st == DONE;
  assign pass = done && err_count == '0;

  // Next state, word-pair index and the drive the RAM will see next cycle
  always_comb begin
    nxt_st = st;
    last   = &k;
    go     = (st == IDLE || st == DONE) && start;
    phase  = st == WR_T || st == RD_T || st == WR_I || st == RD_I;
    unique case (st)
      IDLE, DONE: nxt_st = start ? WR_T : st;
      WR_T:       nxt_st = last ? RD_T : st;
      RD_T:       nxt_st = last ? WR_I : st;
      WR_I:       nxt_st = last ? RD_I : st;
      RD_I:       nxt_st = last ? CHECK : st;
      CHECK:      nxt_st = DONE;
      default:    nxt_st = IDLE;
    endcase
    nxt_k   = (phase && !last) ? k + (ADDR_W-1)'(1) : '0;
    nxt_wr  = nxt_st == WR_T || nxt_st == WR_I;
    nxt_rd  = nxt_st == RD_T || nxt_st == RD_I;
    nxt_inv = nxt_st == WR_I || nxt_st == RD_I;
    ev      = {nxt_k, 1'b0};
    od      = {nxt_k, 1'b1};
    m0      = cmp_v && ram_data0_out != exp0;
    m1      = cmp_v && ram_data1_out != exp1;
  end

  // State and index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      k  <= '0;
    end else begin
      st <= nxt_st;
      k  <= nxt_k;
    end
  end

  // Registered RAM drive; even/odd words swap ports between write and read phases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en       <= 1'b0;
      ram_wr0      <= 1'b1;
      ram_wr1      <= 1'b1;
      ram_add0     <= '0;
      ram_add1     <= '0;
      ram_data0_in <= '0;
      ram_data1_in <= '0;
    end else begin
      ram_en       <= nxt_wr || nxt_rd || nxt_st == CHECK;
      ram_wr0      <= !nxt_wr;
      ram_wr1      <= !nxt_wr;
      ram_add0     <= nxt_wr ? ev : nxt_rd ? od : '0;
      ram_add1     <= nxt_wr ? od : nxt_rd ? ev : '0;
      ram_data0_in <= nxt_wr ? pat(ev, nxt_inv) : '0;
      ram_data1_in <= nxt_wr ? pat(od, nxt_inv) : '0;
    end
  end

  // One-stage delay of expected data and address to line up with RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_v  <= 1'b0;
      exp0   <= '0;
      exp1   <= '0;
      cmp_a0 <= '0;
      cmp_a1 <= '0;
    end else begin
      cmp_v  <= st == RD_T || st == RD_I;
      exp0   <= pat(ram_add0, st == RD_I);
      exp1   <= pat(ram_add1, st == RD_I);
      cmp_a0 <= ram_add0;
      cmp_a1 <= ram_add1;
    end
  end

  // Error accumulation; the first mismatch is latched while the count is still zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      fail_addr <= '0;
      fail_port <= 1'b0;
    end else if (go) begin
      err_count <= '0;
      fail_addr <= '0;
      fail_port <= 1'b0;
    end else if (m0 || m1) begin
      err_count <= err_count + (ADDR_W+2)'(m0) + (ADDR_W+2)'(m1);
      if (err_count == '0) begin
        fail_addr <= m0 ? cmp_a0 : cmp_a1;
        fail_port <= !m0;
      end
    end
  end
endmodule

// File: tb/tb_dpram_bist.sv
// tb_dpram_bist: directed bench with a RAM model, fault injection and a cycle-indexed reference model
module tb_dpram_bist;
  localparam int DEPTH = 64;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic       busy, done, pass, fail_port, ram_en, ram_wr0, ram_wr1;
  logic [7:0] err_count;
  logic [5:0] fail_addr, ram_add0, ram_add1;
  logic [7:0] ram_data0_in, ram_data1_in, ram_data0_out, ram_data1_out;

  int checks = 0, errors = 0, cyc = 0, t0 = 0, fault = 0;
  int t = 0, m_err = 0, m_fa = 0, m_fp = 0;

  dpram_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_port(fail_port),
    .ram_en(ram_en), .ram_wr0(ram_wr0), .ram_wr1(ram_wr1),
    .ram_add0(ram_add0), .ram_add1(ram_add1),
    .ram_data0_in(ram_data0_in), .ram_data1_in(ram_data1_in),
    .ram_data0_out(ram_data0_out), .ram_data1_out(ram_data1_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous read, outputs cleared when disabled; fault 1 sticks bit 0 of word 5 low,
  // fault 2 sticks port-1 read data at zero
  logic [7:0] mem [DEPTH];
  logic [7:0] q0 = 8'h00, q1 = 8'h00;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (!ram_en) begin
      q0 <= 8'h00;
      q1 <= 8'h00;
    end else begin
      if (!ram_wr0) mem[ram_add0] <= (fault == 1 && ram_add0 == 6'd5) ? (ram_data0_in & 8'hFE) : ram_data0_in;
      else q0 <= mem[ram_add0];
      if (!ram_wr1) mem[ram_add1] <= (fault == 1 && ram_add1 == 6'd5) ? (ram_data1_in & 8'hFE) : ram_data1_in;
      else q1 <= mem[ram_add1];
    end
  end
  assign ram_data0_out = q0;
  assign ram_data1_out = (fault == 2) ? 8'h00 : q1;

  function automatic logic [7:0] pat(int a, bit inv);
    logic [7:0] p;
    p = SEED ^ 8'(a);
    return inv ? ~p : p;
  endfunction

  function automatic bit isrd(int c);
    return (c >= 33 && c <= 64) || (c >= 97 && c <= 128);
  endfunction

  function automatic int raddr(int c, int port);
    return port == 0 ? 2 * ((c - 1) % 32) + 1 : 2 * ((c - 1) % 32);
  endfunction

  function automatic bit bad(int c, int port);
    int a;
    logic [7:0] e, g;
    a = raddr(c, port);
    e = pat(a, (c - 1) / 32 >= 2);
    g = (fault == 2 && port == 1) ? 8'h00 : (fault == 1 && a == 5) ? (e & 8'hFE) : e;
    return g != e;
  endfunction

  // Reference model: t is the cycle index since the accepted start (0 idle, 130 done)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= 0; m_err <= 0; m_fa <= 0; m_fp <= 0;
    end else if ((t == 0 || t == 130) && start) begin
      t <= 1; m_err <= 0; m_fa <= 0; m_fp <= 0;
    end else if (t >= 1 && t <= 129) begin
      t <= t + 1;
      if (isrd(t - 1)) begin
        m_err <= m_err + int'(bad(t - 1, 0)) + int'(bad(t - 1, 1));
        if (m_err == 0 && (bad(t - 1, 0) || bad(t - 1, 1))) begin
          m_fa <= bad(t - 1, 0) ? raddr(t - 1, 0) : raddr(t - 1, 1);
          m_fp <= bad(t - 1, 0) ? 0 : 1;
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at time %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  task automatic compare_cycle();
    int k, ph, a0, a1, d0, d1;
    bit w, r, inv, act;
    act = t >= 1 && t <= 129;
    ph  = (t - 1) / 32;
    k   = (t - 1) % 32;
    w   = t >= 1 && t <= 128 && (ph == 0 || ph == 2);
    r   = t >= 1 && t <= 128 && (ph == 1 || ph == 3);
    inv = ph >= 2;
    a0  = w ? 2 * k : r ? 2 * k + 1 : 0;
    a1  = w ? 2 * k + 1 : r ? 2 * k : 0;
    d0  = w ? int'(pat(2 * k, inv)) : 0;
    d1  = w ? int'(pat(2 * k + 1, inv)) : 0;
    chk("busy", 32'(busy), 32'(act));
    chk("done", 32'(done), 32'(t == 130));
    chk("pass", 32'(pass), 32'(t == 130 && m_err == 0));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("fail_addr", 32'(fail_addr), 32'(m_fa));
    chk("fail_port", 32'(fail_port), 32'(m_fp));
    chk("ram_en", 32'(ram_en), 32'(act));
    chk("ram_wr0", 32'(ram_wr0), 32'(!w));
    chk("ram_wr1", 32'(ram_wr1), 32'(!w));
    chk("ram_add0", 32'(ram_add0), 32'(a0));
    chk("ram_add1", 32'(ram_add1), 32'(a1));
    chk("ram_data0_in", 32'(ram_data0_in), 32'(d0));
    chk("ram_data1_in", 32'(ram_data1_in), 32'(d1));
  endtask

  always @(negedge clk) compare_cycle();

  task automatic pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(output int n);
    n = cyc - t0 + 1;
    while (!done && n < 300) begin
      @(negedge clk);
      #1 n = cyc - t0 + 1;
    end
    if (!done) begin
      errors++;
      $display("FAIL wait_done: done not seen within 300 cycles");
    end
  endtask

  initial begin
    int n;
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ram_wr0", 32'(ram_wr0), 32'd1);
    chk("reset ram_en", 32'(ram_en), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    pulse_start();
    #3;
    chk("first add0", 32'(ram_add0), 32'h00);
    chk("first data0", 32'(ram_data0_in), 32'hA5);
    chk("first add1", 32'(ram_add1), 32'h01);
    chk("first data1", 32'(ram_data1_in), 32'hA4);
    repeat (38) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(n);
    chk("clean done cycle", 32'(n), 32'd130);
    chk("clean pass", 32'(pass), 32'd1);
    chk("clean err", 32'(err_count), 32'd0);

    fault = 1;
    pulse_start();
    wait_done(n);
    chk("stuck bit done cycle", 32'(n), 32'd130);
    chk("stuck bit pass", 32'(pass), 32'd0);
    chk("stuck bit err", 32'(err_count), 32'd1);
    chk("stuck bit addr", 32'(fail_addr), 32'd5);
    chk("stuck bit port", 32'(fail_port), 32'd0);

    fault = 2;
    pulse_start();
    wait_done(n);
    chk("port1 zero pass", 32'(pass), 32'd0);
    chk("port1 zero err", 32'(err_count), 32'd64);
    chk("port1 zero addr", 32'(fail_addr), 32'd0);
    chk("port1 zero port", 32'(fail_port), 32'd1);

    fault = 0;
    pulse_start();
    #3;
    chk("restart done", 32'(done), 32'd0);
    chk("restart err", 32'(err_count), 32'd0);
    chk("restart port", 32'(fail_port), 32'd0);
    chk("restart busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("rerun pass", 32'(pass), 32'd1);

    pulse_start();
    repeat (49) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ram_en", 32'(ram_en), 32'd0);
    chk("abort ram_wr1", 32'(ram_wr1), 32'd1);
    chk("abort ram_add0", 32'(ram_add0), 32'd0);
    chk("abort ram_data1", 32'(ram_data1_in), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    pulse_start();
    wait_done(n);
    chk("post abort done cycle", 32'(n), 32'd130);
    chk("post abort pass", 32'(pass), 32'd1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
